// File: rtl/ft600_fifo_bus_model.sv
// ---------------------------------------------------------------------------
// ft600_fifo_bus_model
//   Behavioural model of an FT600-style 245 synchronous FIFO bridge. It holds
//   two independent first-word-fall-through FIFOs:
//     H2F : loaded by the host model, drained by the FPGA over the FIFO bus
//     F2H : loaded by the FPGA over the FIFO bus, drained by the host model
//   Ports
//     ftdi_clk, rst_n          : sole clock (rising edge), async active-low reset
//     ftdi_rxf_n / ftdi_txe_n  : registered H2F-data-available / F2H-space flags
//     ftdi_oe_n/rd_n/wr_n      : FPGA bus strobes, all active low
//     ftdi_data_i / ftdi_be_i  : bus data/byte enables written by the FPGA
//     ftdi_data_o / ftdi_be_o  : H2F head presented to the FPGA
//     ftdi_bus_drive           : tri-state enable for ftdi_data_o/ftdi_be_o
//     host_tx_*                : {be,data} push side of H2F
//     host_rx_*                : {be,data} pop side of F2H
//     rd_err/wr_err/bus_err    : sticky protocol violation flags
// ---------------------------------------------------------------------------
module ft600_fifo_bus_model #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 16,
  parameter int BE_WIDTH   = 2
) (
  input  logic                         ftdi_clk,
  input  logic                         rst_n,
  output logic                         ftdi_rxf_n,
  output logic                         ftdi_txe_n,
  input  logic                         ftdi_oe_n,
  input  logic                         ftdi_rd_n,
  input  logic                         ftdi_wr_n,
  input  logic [DATA_WIDTH-1:0]        ftdi_data_i,
  input  logic [BE_WIDTH-1:0]          ftdi_be_i,
  output logic [DATA_WIDTH-1:0]        ftdi_data_o,
  output logic [BE_WIDTH-1:0]          ftdi_be_o,
  output logic                         ftdi_bus_drive,
  input  logic [BE_WIDTH+DATA_WIDTH-1:0] host_tx_data,
  input  logic                         host_tx_valid,
  output logic                         host_tx_ready,
  output logic [BE_WIDTH+DATA_WIDTH-1:0] host_rx_data,
  output logic                         host_rx_valid,
  input  logic                         host_rx_ready,
  output logic                         rd_err,
  output logic                         wr_err,
  output logic                         bus_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = BE_WIDTH + DATA_WIDTH;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WW-1:0] h2f_mem [DEPTH];
  logic [WW-1:0] f2h_mem [DEPTH];

  // Pointers carry one extra MSB so full and empty differ only by wrap parity.
  logic [AW:0] h2f_wr_q, h2f_rd_q, f2h_wr_q, f2h_rd_q;
  logic [AW:0] h2f_cnt, f2h_cnt, h2f_cnt_d, f2h_cnt_d;
  logic        rxf_n_q, txe_n_q, tx_ready_q;
  logic        rd_err_q, wr_err_q, bus_err_q;
  logic        h2f_push, h2f_pop, f2h_push, f2h_pop;

  assign h2f_cnt = h2f_wr_q - h2f_rd_q;
  assign f2h_cnt = f2h_wr_q - f2h_rd_q;

  assign h2f_push = host_tx_valid & tx_ready_q;
  assign h2f_pop  = ~ftdi_oe_n & ~ftdi_rd_n & ~rxf_n_q;
  // A write with OE asserted is a bus conflict and must not land in the FIFO.
  assign f2h_push = ~ftdi_wr_n & ~txe_n_q & ftdi_oe_n;
  assign f2h_pop  = host_rx_valid & host_rx_ready;

  assign h2f_cnt_d = h2f_cnt + {{AW{1'b0}}, h2f_push} - {{AW{1'b0}}, h2f_pop};
  assign f2h_cnt_d = f2h_cnt + {{AW{1'b0}}, f2h_push} - {{AW{1'b0}}, f2h_pop};

  // Pointer and flag state; flags are registered from the next-state counts.
  always_ff @(posedge ftdi_clk or negedge rst_n) begin
    if (!rst_n) begin
      h2f_wr_q   <= '0;
      h2f_rd_q   <= '0;
      f2h_wr_q   <= '0;
      f2h_rd_q   <= '0;
      rxf_n_q    <= 1'b1;
      txe_n_q    <= 1'b1;
      tx_ready_q <= 1'b0;
      rd_err_q   <= 1'b0;
      wr_err_q   <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      if (h2f_push) h2f_wr_q <= h2f_wr_q + 1'b1;
      if (h2f_pop)  h2f_rd_q <= h2f_rd_q + 1'b1;
      if (f2h_push) f2h_wr_q <= f2h_wr_q + 1'b1;
      if (f2h_pop)  f2h_rd_q <= f2h_rd_q + 1'b1;
      rxf_n_q    <= (h2f_cnt_d == '0);
      tx_ready_q <= (h2f_cnt_d != FULL_CNT);
      txe_n_q    <= (f2h_cnt_d == FULL_CNT);
      rd_err_q   <= rd_err_q  | (~ftdi_oe_n & ~ftdi_rd_n & rxf_n_q);
      wr_err_q   <= wr_err_q  | (~ftdi_wr_n & txe_n_q);
      bus_err_q  <= bus_err_q | (~ftdi_oe_n & ~ftdi_wr_n);
    end
  end

  // Storage arrays are not reset; the pointers alone define their contents.
  always_ff @(posedge ftdi_clk) begin
    if (h2f_push) h2f_mem[h2f_wr_q[AW-1:0]] <= host_tx_data;
    if (f2h_push) f2h_mem[f2h_wr_q[AW-1:0]] <= {ftdi_be_i, ftdi_data_i};
  end

  // First-word-fall-through: heads are read combinationally from the arrays.
  assign {ftdi_be_o, ftdi_data_o} = h2f_mem[h2f_rd_q[AW-1:0]];
  assign host_rx_data   = f2h_mem[f2h_rd_q[AW-1:0]];
  assign host_rx_valid  = (f2h_cnt != '0);
  assign host_tx_ready  = tx_ready_q;
  assign ftdi_rxf_n     = rxf_n_q;
  assign ftdi_txe_n     = txe_n_q;
  assign ftdi_bus_drive = ~ftdi_oe_n & ftdi_wr_n;
  assign rd_err         = rd_err_q;
  assign wr_err         = wr_err_q;
  assign bus_err        = bus_err_q;

endmodule

// File: tb/tb_ft600_fifo_bus_model.sv
module tb_ft600_fifo_bus_model;

  localparam int DEPTH = 16;

  logic        ftdi_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ftdi_rxf_n, ftdi_txe_n;
  logic        ftdi_oe_n = 1'b1, ftdi_rd_n = 1'b1, ftdi_wr_n = 1'b1;
  logic [15:0] ftdi_data_i = '0;
  logic [1:0]  ftdi_be_i = '0;
  logic [15:0] ftdi_data_o;
  logic [1:0]  ftdi_be_o;
  logic        ftdi_bus_drive;
  logic [17:0] host_tx_data = '0;
  logic        host_tx_valid = 1'b0;
  logic        host_tx_ready;
  logic [17:0] host_rx_data;
  logic        host_rx_valid;
  logic        host_rx_ready = 1'b0;
  logic        rd_err, wr_err, bus_err;

  int checks = 0;
  int errors = 0;

  ft600_fifo_bus_model #(.DEPTH(DEPTH), .DATA_WIDTH(16), .BE_WIDTH(2)) dut (
    .ftdi_clk(ftdi_clk), .rst_n(rst_n),
    .ftdi_rxf_n(ftdi_rxf_n), .ftdi_txe_n(ftdi_txe_n),
    .ftdi_oe_n(ftdi_oe_n), .ftdi_rd_n(ftdi_rd_n), .ftdi_wr_n(ftdi_wr_n),
    .ftdi_data_i(ftdi_data_i), .ftdi_be_i(ftdi_be_i),
    .ftdi_data_o(ftdi_data_o), .ftdi_be_o(ftdi_be_o),
    .ftdi_bus_drive(ftdi_bus_drive),
    .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid),
    .host_tx_ready(host_tx_ready),
    .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid),
    .host_rx_ready(host_rx_ready),
    .rd_err(rd_err), .wr_err(wr_err), .bus_err(bus_err)
  );

  always #5 ftdi_clk = ~ftdi_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ftdi_clk);
    #1;
  endtask

  // ---------------- behavioural model: two queues plus flag rules ----------
  logic [17:0] m_h2f[$];
  logic [17:0] m_f2h[$];
  logic m_rxf_n = 1'b1, m_txe_n = 1'b1, m_tx_ready = 1'b0;
  logic m_rd_err = 1'b0, m_wr_err = 1'b0, m_bus_err = 1'b0;
  bit   h_pop, h_push, f_push, f_pop;

  always @(posedge ftdi_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_h2f.delete();
      m_f2h.delete();
      m_rxf_n    <= 1'b1;
      m_txe_n    <= 1'b1;
      m_tx_ready <= 1'b0;
      m_rd_err   <= 1'b0;
      m_wr_err   <= 1'b0;
      m_bus_err  <= 1'b0;
    end else begin
      h_pop  = !ftdi_oe_n && !ftdi_rd_n && !m_rxf_n && (m_h2f.size() > 0);
      h_push = host_tx_valid && m_tx_ready;
      f_push = !ftdi_wr_n && !m_txe_n && ftdi_oe_n;
      f_pop  = host_rx_ready && (m_f2h.size() > 0);
      if (!ftdi_oe_n && !ftdi_rd_n && m_rxf_n) m_rd_err <= 1'b1;
      if (!ftdi_wr_n && m_txe_n)               m_wr_err <= 1'b1;
      if (!ftdi_oe_n && !ftdi_wr_n)            m_bus_err <= 1'b1;
      if (h_pop)  void'(m_h2f.pop_front());
      if (h_push) m_h2f.push_back(host_tx_data);
      if (f_pop)  void'(m_f2h.pop_front());
      if (f_push) m_f2h.push_back({ftdi_be_i, ftdi_data_i});
      m_rxf_n    <= (m_h2f.size() == 0);
      m_tx_ready <= (m_h2f.size() != DEPTH);
      m_txe_n    <= (m_f2h.size() == DEPTH);
    end
  end

  // Compare process on the falling edge, away from the active edge.
  always @(negedge ftdi_clk) begin
    chk("rxf_n", ftdi_rxf_n, m_rxf_n);
    chk("txe_n", ftdi_txe_n, m_txe_n);
    chk("tx_ready", host_tx_ready, m_tx_ready);
    chk("rx_valid", host_rx_valid, m_f2h.size() > 0);
    chk("rd_err", rd_err, m_rd_err);
    chk("wr_err", wr_err, m_wr_err);
    chk("bus_err", bus_err, m_bus_err);
    chk("bus_drive", ftdi_bus_drive, !ftdi_oe_n && ftdi_wr_n);
    if (!m_rxf_n && m_h2f.size() > 0)
      chk("h2f_head", {ftdi_be_o, ftdi_data_o}, m_h2f[0]);
    if (m_f2h.size() > 0)
      chk("f2h_head", host_rx_data, m_f2h[0]);
  end

  logic [15:0] tbl [8] = '{16'h3130, 16'h3332, 16'h3534, 16'h3736,
                           16'h3938, 16'h6261, 16'h6463, 16'h6665};

  initial begin
    // Reset state
    repeat (2) @(posedge ftdi_clk);
    #1;
    chk("rst_rxf_n", ftdi_rxf_n, 1'b1);
    chk("rst_txe_n", ftdi_txe_n, 1'b1);
    chk("rst_tx_ready", host_tx_ready, 1'b0);
    chk("rst_rx_valid", host_rx_valid, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("rel_txe_n", ftdi_txe_n, 1'b0);
    chk("rel_tx_ready", host_tx_ready, 1'b1);
    $display("reset released");

    // H2F streaming: 8 words loaded, then 8 back-to-back pops
    for (int i = 0; i < 8; i++) begin
      host_tx_data = {2'b11, tbl[i]};
      host_tx_valid = 1'b1;
      tick();
      $display("host push %h", host_tx_data);
    end
    host_tx_valid = 1'b0;
    ftdi_oe_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("h2f_word", {ftdi_be_o, ftdi_data_o}, {2'b11, tbl[i]});
      chk("h2f_rxf_low", ftdi_rxf_n, 1'b0);
      ftdi_rd_n = 1'b0;
      tick();
      $display("fpga pop %0d", i);
    end
    ftdi_rd_n = 1'b1;
    ftdi_oe_n = 1'b1;
    chk("h2f_empty_rxf", ftdi_rxf_n, 1'b1);

    // F2H: FPGA writes 8 words, host reads them back
    for (int i = 0; i < 8; i++) begin
      ftdi_wr_n = 1'b0;
      ftdi_data_i = tbl[i];
      ftdi_be_i = 2'b11;
      tick();
      chk("f2h_txe_low", ftdi_txe_n, 1'b0);
      $display("fpga write %h", tbl[i]);
    end
    ftdi_wr_n = 1'b1;
    host_rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("f2h_word", host_rx_data, {2'b11, tbl[i]});
      tick();
      $display("host pop %0d", i);
    end
    host_rx_ready = 1'b0;
    chk("f2h_empty", host_rx_valid, 1'b0);

    // F2H full and overflow
    for (int i = 0; i < DEPTH; i++) begin
      ftdi_wr_n = 1'b0;
      ftdi_data_i = 16'h1000 + 16'(i);
      ftdi_be_i = 2'(i);
      tick();
      if (i == DEPTH - 2) chk("f2h_almost_full_txe", ftdi_txe_n, 1'b0);
      $display("fill write %0d", i);
    end
    chk("f2h_full_txe", ftdi_txe_n, 1'b1);
    ftdi_data_i = 16'hDEAD;
    tick();
    ftdi_wr_n = 1'b1;
    chk("overflow_wr_err", wr_err, 1'b1);
    chk("overflow_head", host_rx_data, {2'b00, 16'h1000});
    host_rx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_word", host_rx_data, {2'(i), 16'h1000 + 16'(i)});
      tick();
    end
    host_rx_ready = 1'b0;
    chk("drain_empty", host_rx_valid, 1'b0);
    $display("overflow scenario done");

    // Read underflow and bus conflict
    ftdi_oe_n = 1'b0;
    ftdi_rd_n = 1'b0;
    tick();
    ftdi_rd_n = 1'b1;
    chk("underflow_rd_err", rd_err, 1'b1);
    chk("underflow_rxf", ftdi_rxf_n, 1'b1);
    ftdi_wr_n = 1'b0;
    ftdi_data_i = 16'hBEEF;
    #1;
    chk("conflict_drive", ftdi_bus_drive, 1'b0);
    tick();
    ftdi_wr_n = 1'b1;
    ftdi_oe_n = 1'b1;
    chk("conflict_bus_err", bus_err, 1'b1);
    chk("conflict_no_push", host_rx_valid, 1'b0);
    $display("error scenario done");

    // Concurrent push and pop at count 1
    host_tx_data = {2'b01, 16'hAAAA};
    host_tx_valid = 1'b1;
    tick();
    host_tx_data = {2'b10, 16'h5555};
    ftdi_oe_n = 1'b0;
    ftdi_rd_n = 1'b0;
    chk("conc_head_a", {ftdi_be_o, ftdi_data_o}, {2'b01, 16'hAAAA});
    tick();
    host_tx_valid = 1'b0;
    chk("conc_rxf", ftdi_rxf_n, 1'b0);
    chk("conc_head_b", {ftdi_be_o, ftdi_data_o}, {2'b10, 16'h5555});
    tick();
    ftdi_rd_n = 1'b1;
    ftdi_oe_n = 1'b1;
    chk("conc_empty", ftdi_rxf_n, 1'b1);
    $display("concurrent scenario done");

    // Reset mid-burst with 5 words queued
    for (int i = 0; i < 5; i++) begin
      host_tx_data = {2'b11, 16'h7000 + 16'(i)};
      host_tx_valid = 1'b1;
      tick();
    end
    host_tx_valid = 1'b0;
    ftdi_wr_n = 1'b0;
    ftdi_data_i = 16'h4242;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rxf", ftdi_rxf_n, 1'b1);
    chk("mid_rst_txe", ftdi_txe_n, 1'b1);
    chk("mid_rst_tx_ready", host_tx_ready, 1'b0);
    chk("mid_rst_rx_valid", host_rx_valid, 1'b0);
    chk("mid_rst_errs", {rd_err, wr_err, bus_err}, 3'b000);
    ftdi_wr_n = 1'b1;
    tick();
    rst_n = 1'b1;
    chk("post_rst_txe_hold", ftdi_txe_n, 1'b1);
    tick();
    chk("post_rst_txe", ftdi_txe_n, 1'b0);
    chk("post_rst_tx_ready", host_tx_ready, 1'b1);
    chk("post_rst_rxf", ftdi_rxf_n, 1'b1);
    chk("post_rst_rx_valid", host_rx_valid, 1'b0);
    tick();
    $display("reset scenario done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ft600_fifo_bus_model.md
FT600_FIFO_BUS_MODEL -- requirements
Module: ft600_fifo_bus_model

Interface
REQ-001 Parameters SHALL be: DEPTH, 16, entries per direction (power of 2, >=4); DATA_WIDTH, 16, bus data bits; BE_WIDTH, 2, byte-enable bits.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset.
REQ-003 Ports SHALL be:
  ftdi_clk  in  1  sole clock, all state on rising edge
  rst_n  in  1  async active-low reset
  ftdi_rxf_n  out  1  low = host-to-FPGA (H2F) data available
  ftdi_txe_n  out  1  low = FPGA-to-host (F2H) space available
  ftdi_oe_n  in  1  FPGA output-enable request, active low
  ftdi_rd_n  in  1  FPGA read strobe, active low
  ftdi_wr_n  in  1  FPGA write strobe, active low
  ftdi_data_i  in  DATA_WIDTH  bus data driven by FPGA
  ftdi_be_i  in  BE_WIDTH  bus byte enables driven by FPGA
  ftdi_data_o  out  DATA_WIDTH  bus data toward FPGA
  ftdi_be_o  out  BE_WIDTH  byte enables toward FPGA
  ftdi_bus_drive  out  1  tri-state enable for ftdi_data_o/ftdi_be_o
  host_tx_data  in  BE_WIDTH+DATA_WIDTH  {be,data} word to load into H2F
  host_tx_valid  in  1  host_tx_data valid
  host_tx_ready  out  1  H2F not full
  host_rx_data  out  BE_WIDTH+DATA_WIDTH  {be,data} head of F2H
  host_rx_valid  out  1  F2H not empty
  host_rx_ready  in  1  host consumes host_rx_data
  rd_err  out  1  sticky: read strobe while H2F empty
  wr_err  out  1  sticky: write strobe while F2H full
  bus_err  out  1  sticky: ftdi_oe_n and ftdi_wr_n low same cycle

Function
REQ-004 H2F and F2H SHALL be independent first-word-fall-through FIFOs of DEPTH entries, width BE_WIDTH+DATA_WIDTH, with log2(DEPTH)+1-bit pointers; wrap-around SHALL be by pointer MSB toggle.
REQ-005 H2F push SHALL occur on a rising edge with host_tx_valid=1 and host_tx_ready=1; host_tx_ready SHALL be 0 exactly when H2F holds DEPTH entries.
REQ-006 H2F pop SHALL occur on a rising edge with ftdi_oe_n=0, ftdi_rd_n=0, ftdi_rxf_n=0; push and pop in the same cycle SHALL leave the count unchanged.
REQ-007 ftdi_data_o/ftdi_be_o SHALL combinationally present the H2F head; the next word SHALL appear the cycle after each pop (zero-bubble streaming).
REQ-008 ftdi_bus_drive SHALL equal (ftdi_oe_n==0 AND ftdi_wr_n==1); no other condition SHALL drive the bus.
REQ-009 ftdi_rxf_n SHALL be registered, equal to (next H2F count==0); after the last word is popped it SHALL be 1 on the following cycle.
REQ-010 F2H push SHALL occur on a rising edge with ftdi_wr_n=0, ftdi_txe_n=0, ftdi_oe_n=1, capturing {ftdi_be_i, ftdi_data_i}.
REQ-011 ftdi_txe_n SHALL be registered, equal to (next F2H count==DEPTH).
REQ-012 F2H pop SHALL occur on host_rx_valid=1 and host_rx_ready=1; host_rx_valid SHALL be 1 exactly when F2H is non-empty.
REQ-013 ftdi_rd_n=0 with ftdi_oe_n=0 and ftdi_rxf_n=1 SHALL pop nothing and set rd_err.
REQ-014 ftdi_wr_n=0 with ftdi_txe_n=1 SHALL push nothing and set wr_err.
REQ-015 ftdi_oe_n=0 with ftdi_wr_n=0 SHALL push nothing, drive nothing, and set bus_err.
REQ-016 Error flags SHALL clear only on reset.

Reset
REQ-017 rst_n=0 SHALL immediately empty both FIFOs and force ftdi_rxf_n=1, ftdi_txe_n=1, host_tx_ready=0, host_rx_valid=0, rd_err=wr_err=bus_err=0, ftdi_bus_drive per REQ-008.
REQ-018 After rst_n rises, the first rising edge SHALL set ftdi_txe_n=0 and host_tx_ready=1; reset mid-transfer SHALL discard all in-flight words.

Verification
REQ-019 Load 8 words 0x3130..0x6665, be=2'b11; FPGA holds oe_n/rd_n low -> 8 consecutive pops in order, ftdi_rxf_n=1 the cycle after the 8th.
REQ-020 FPGA writes 8 words with wr_n low, oe_n high -> host_rx_data yields the same 8 {be,data} in order; ftdi_txe_n stays 0.
REQ-021 F2H filled to DEPTH with host_rx_ready=0 -> ftdi_txe_n=1; extra wr_n cycle sets wr_err, count stays DEPTH.
REQ-022 rd_n low with H2F empty -> rd_err=1, ftdi_rxf_n=1, no pop; oe_n and wr_n both low -> bus_err=1, ftdi_bus_drive=0.
REQ-023 Host push concurrent with FPGA pop at count 1 -> count stays 1, ftdi_rxf_n stays 0, data order preserved.
REQ-024 rst_n pulsed low mid-burst with 5 words queued -> both FIFOs empty, all flags at REQ-017 values, ftdi_txe_n=0 one edge after release.
